// File: rtl/pipe_ctrl_unit.sv
// pipe_ctrl_unit: pipeline control for the 5-stage Y86-64 core.
// Drives stall/bubble controls for the F/D/E/M/W register banks, gates CC
// writes and sequences the core run state IDLE -> RUN -> HALT.
// Optional build macro PIPE_CTRL_PERF_EN adds RUN-cycle, stall and bubble
// performance counters.
module pipe_ctrl_unit #(
  parameter int ICODE_W = 4,
  parameter int REG_W   = 4,
  parameter int STAT_W  = 3,
  parameter int CNT_W   = 32
) (
  input  logic               clk,
  input  logic               async_reset,
  input  logic               start,
  input  logic [ICODE_W-1:0] D_icode,
  input  logic [ICODE_W-1:0] E_icode,
  input  logic [ICODE_W-1:0] M_icode,
  input  logic [REG_W-1:0]   E_dstM,
  input  logic [REG_W-1:0]   d_srcA,
  input  logic [REG_W-1:0]   d_srcB,
  input  logic               e_Cnd,
  input  logic [STAT_W-1:0]  m_stat,
  input  logic [STAT_W-1:0]  W_stat,
  output logic               F_stall,
  output logic               D_stall,
  output logic               D_bubble,
  output logic               E_bubble,
  output logic               M_bubble,
  output logic               W_stall,
  output logic               set_cc,
  output logic               busy,
  output logic               halted,
  output logic [STAT_W-1:0]  cpu_stat
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [CNT_W-1:0]   perf_cycles,
  output logic [CNT_W-1:0]   perf_stalls,
  output logic [CNT_W-1:0]   perf_bubbles
`endif
);

  localparam logic [ICODE_W-1:0] IC_OPQ    = ICODE_W'(6);
  localparam logic [ICODE_W-1:0] IC_JXX    = ICODE_W'(7);
  localparam logic [ICODE_W-1:0] IC_RET    = ICODE_W'(9);
  localparam logic [ICODE_W-1:0] IC_MRMOVQ = ICODE_W'(5);
  localparam logic [ICODE_W-1:0] IC_POPQ   = ICODE_W'(11);
  localparam logic [REG_W-1:0]   RNONE     = '1;
  localparam logic [STAT_W-1:0]  S_AOK     = STAT_W'(1);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, HALT = 2'd2} state_t;

  state_t st, nxt;
  logic   lu, ret, mis, exc, w_exc;

  // Hazard terms; only consulted while running
  always_comb begin
    lu    = ((E_icode == IC_MRMOVQ) || (E_icode == IC_POPQ)) && (E_dstM != RNONE) &&
            ((E_dstM == d_srcA) || (E_dstM == d_srcB));
    ret   = (D_icode == IC_RET) || (E_icode == IC_RET) || (M_icode == IC_RET);
    mis   = (E_icode == IC_JXX) && !e_Cnd;
    w_exc = (W_stat != S_AOK);
    exc   = (m_stat != S_AOK) || w_exc;
  end

  // Run-state register; reset aborts immediately, HALT is left only by reset
  always_ff @(posedge clk or negedge async_reset) begin
    if (!async_reset) st <= IDLE;
    else              st <= nxt;
  end

  // Next state and bank controls; IDLE/HALT freeze the front end and flush D/E/M
  always_comb begin
    nxt      = st;
    F_stall  = 1'b1;
    D_stall  = 1'b0;
    D_bubble = 1'b1;
    E_bubble = 1'b1;
    M_bubble = 1'b1;
    W_stall  = 1'b0;
    set_cc   = 1'b0;
    busy     = 1'b0;
    halted   = 1'b0;
    case (st)
      IDLE: if (start) nxt = RUN;
      RUN: begin
        busy     = 1'b1;
        F_stall  = lu | ret;
        D_stall  = lu;
        // a load/use on a ret source stalls D rather than bubbling it
        D_bubble = mis | (ret & ~lu);
        E_bubble = mis | lu;
        M_bubble = exc;
        W_stall  = w_exc;
        set_cc   = (E_icode == IC_OPQ) & ~exc;
        if (w_exc) nxt = HALT;
      end
      HALT: begin
        W_stall = 1'b1;
        halted  = 1'b1;
      end
      default: nxt = IDLE;
    endcase
  end

  // Core status: latch the faulting W status on the edge that enters HALT
  always_ff @(posedge clk or negedge async_reset) begin
    if (!async_reset)             cpu_stat <= S_AOK;
    else if (st == RUN && w_exc)  cpu_stat <= W_stat;
  end

`ifdef PIPE_CTRL_PERF_EN
  // Perf counters advance only while running and wrap naturally
  always_ff @(posedge clk or negedge async_reset) begin
    if (!async_reset) begin
      perf_cycles  <= '0;
      perf_stalls  <= '0;
      perf_bubbles <= '0;
    end else if (st == RUN) begin
      perf_cycles <= perf_cycles + CNT_W'(1);
      if (F_stall)             perf_stalls  <= perf_stalls + CNT_W'(1);
      if (D_bubble | E_bubble) perf_bubbles <= perf_bubbles + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// tb_pipe_ctrl_unit: directed scenarios plus randomized traffic, checked every
// cycle against a behavioural model of the pipeline control rules.
module tb_pipe_ctrl_unit;

  logic       clk = 1'b0;
  logic       async_reset = 1'b0;
  logic       start = 1'b0;
  logic [3:0] D_icode = 4'h1, E_icode = 4'h1, M_icode = 4'h1;
  logic [3:0] E_dstM = 4'hF, d_srcA = 4'hF, d_srcB = 4'hF;
  logic       e_Cnd = 1'b1;
  logic [2:0] m_stat = 3'd1, W_stat = 3'd1;
  logic       F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, set_cc, busy, halted;
  logic [2:0] cpu_stat;
`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] perf_cycles, perf_stalls, perf_bubbles;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  pipe_ctrl_unit dut (
    .clk(clk), .async_reset(async_reset), .start(start),
    .D_icode(D_icode), .E_icode(E_icode), .M_icode(M_icode),
    .E_dstM(E_dstM), .d_srcA(d_srcA), .d_srcB(d_srcB), .e_Cnd(e_Cnd),
    .m_stat(m_stat), .W_stat(W_stat),
    .F_stall(F_stall), .D_stall(D_stall), .D_bubble(D_bubble), .E_bubble(E_bubble),
    .M_bubble(M_bubble), .W_stall(W_stall), .set_cc(set_cc), .busy(busy),
    .halted(halted), .cpu_stat(cpu_stat)
`ifdef PIPE_CTRL_PERF_EN
    , .perf_cycles(perf_cycles), .perf_stalls(perf_stalls), .perf_bubbles(perf_bubbles)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, expv, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // phase: 0 idle, 1 running, 2 halted
  int          m_ph = 0;
  logic [2:0]  m_cpu = 3'd1;
  longint      m_cyc = 0, m_stl = 0, m_bub = 0;

  // {F_stall,D_stall,D_bubble,E_bubble,M_bubble,W_stall,set_cc,busy,halted}
  function automatic logic [8:0] model_outs(int ph);
    bit lu, rt, mis, exc, f, db, eb;
    if (ph == 0) return 9'b1_0_1_1_1_0_0_0_0;
    if (ph == 2) return 9'b1_0_1_1_1_1_0_0_1;
    lu  = (E_icode == 4'd5 || E_icode == 4'd11) && E_dstM != 4'hF &&
          (E_dstM == d_srcA || E_dstM == d_srcB);
    rt  = (D_icode == 4'd9) || (E_icode == 4'd9) || (M_icode == 4'd9);
    mis = (E_icode == 4'd7) && !e_Cnd;
    exc = (m_stat != 3'd1) || (W_stat != 3'd1);
    f   = lu || rt;
    db  = mis || (rt && !lu);
    eb  = mis || lu;
    return {f, lu, db, eb, exc, W_stat != 3'd1, (E_icode == 4'd6) && !exc, 1'b1, 1'b0};
  endfunction

  // Per-cycle compare, then advance the model across the coming rising edge
  always @(negedge clk) begin
    logic [8:0] ev;
    if (!async_reset) begin
      m_ph = 0; m_cpu = 3'd1; m_cyc = 0; m_stl = 0; m_bub = 0;
    end
    ev = model_outs(m_ph);
    chk("outs", {F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, set_cc, busy, halted}, ev);
    chk("cpu_stat", cpu_stat, m_cpu);
`ifdef PIPE_CTRL_PERF_EN
    chk("perf_cycles", perf_cycles, m_cyc[31:0]);
    chk("perf_stalls", perf_stalls, m_stl[31:0]);
    chk("perf_bubbles", perf_bubbles, m_bub[31:0]);
`endif
    if (async_reset) begin
      if (m_ph == 0) begin
        if (start) m_ph = 1;
      end else if (m_ph == 1) begin
        m_cyc++;
        if (ev[8]) m_stl++;
        if (ev[6] || ev[5]) m_bub++;
        if (W_stat != 3'd1) begin m_ph = 2; m_cpu = W_stat; end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic quiet();
    D_icode = 4'h1; E_icode = 4'h1; M_icode = 4'h1;
    E_dstM = 4'hF; d_srcA = 4'hF; d_srcB = 4'hF;
    e_Cnd = 1'b1; m_stat = 3'd1; W_stat = 3'd1;
  endtask

  task automatic do_reset();
    async_reset = 1'b0; start = 1'b0; quiet();
    tick(); tick();
    async_reset = 1'b1;
  endtask

  task automatic do_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  initial begin
    do_reset();
    // 1: idle with no start
    repeat (5) tick();
    #2;
    chk("idle_F_stall", F_stall, 1'b1);
    chk("idle_bubbles", {D_bubble, E_bubble, M_bubble}, 3'b111);
    chk("idle_busy", busy, 1'b0);
    chk("idle_cpu_stat", cpu_stat, 3'd1);
    do_start(); #2;
    chk("start_busy", busy, 1'b1);

    // 2: load/use
    E_icode = 4'd5; E_dstM = 4'd3; d_srcB = 4'd3; #2;
    chk("lu_ctrl", {F_stall, D_stall, E_bubble, D_bubble}, 4'b1110);
    tick();
    E_dstM = 4'hF; d_srcA = 4'hF; #2;
    chk("lu_rnone", {F_stall, D_stall, E_bubble, D_bubble}, 4'b0000);
    tick(); quiet();

    // 3: ret walking down the pipe
    D_icode = 4'd9; #2;
    chk("ret_D", {F_stall, D_bubble}, 2'b11);
    tick(); D_icode = 4'h1; E_icode = 4'd9; #2;
    chk("ret_E", {F_stall, D_bubble}, 2'b11);
    tick(); E_icode = 4'h1; M_icode = 4'd9; #2;
    chk("ret_M", {F_stall, D_bubble}, 2'b11);
    tick(); M_icode = 4'h1; #2;
    chk("ret_done", {F_stall, D_stall, D_bubble, E_bubble}, 4'b0000);

    // 4: mispredicted jump
    tick(); E_icode = 4'd7; e_Cnd = 1'b0; #2;
    chk("mis", {D_bubble, E_bubble, F_stall}, 3'b110);
    tick(); e_Cnd = 1'b1; #2;
    chk("jxx_taken", {D_bubble, E_bubble}, 2'b00);
    tick(); quiet();

    // 5: exceptions and halt
    E_icode = 4'd6; m_stat = 3'd3; #2;
    chk("exc_set_cc", set_cc, 1'b0);
    chk("exc_M_bubble", M_bubble, 1'b1);
    tick(); W_stat = 3'd3; #2;
    chk("w_stall", {W_stall, halted}, 2'b10);
    tick(); #2;
    chk("halt", {halted, busy}, 2'b10);
    chk("halt_cpu_stat", cpu_stat, 3'd3);
    do_start(); #2;
    chk("halt_start_ignored", {halted, busy, cpu_stat}, {2'b10, 3'd3});

    // 6: perf window, then reset mid-run with load/use active
    do_reset(); do_start();
    for (int i = 0; i < 10; i++) begin
      quiet();
      if (i == 2 || i == 6) begin E_icode = 4'd11; E_dstM = 4'd4; d_srcA = 4'd4; end
      tick();
    end
`ifdef PIPE_CTRL_PERF_EN
    chk("perf_cycles10", perf_cycles, 32'd10);
    chk("perf_stalls2", perf_stalls, 32'd2);
    chk("perf_bubbles2", perf_bubbles, 32'd2);
`endif
    E_icode = 4'd5; E_dstM = 4'd2; d_srcA = 4'd2; #2;
    chk("pre_abort_lu", {busy, D_stall}, 2'b11);
    async_reset = 1'b0; #1;
    chk("abort_outs", {F_stall, D_stall, D_bubble, E_bubble, M_bubble, busy, halted}, 7'b1011100);
`ifdef PIPE_CTRL_PERF_EN
    chk("abort_perf", {perf_cycles, perf_stalls}, 64'd0);
`endif
    tick(); async_reset = 1'b1; quiet();

    // randomized traffic, checked by the per-cycle model
    for (int c = 0; c < 3000; c++) begin
      if (c % 150 == 149) begin
        async_reset = 1'b0; tick(); async_reset = 1'b1;
      end
      D_icode = 4'($urandom_range(0, 15));
      E_icode = 4'($urandom_range(0, 15));
      M_icode = 4'($urandom_range(0, 15));
      E_dstM  = 4'($urandom_range(0, 15));
      d_srcA  = 4'($urandom_range(0, 15));
      d_srcB  = 4'($urandom_range(0, 15));
      e_Cnd   = 1'($urandom_range(0, 1));
      m_stat  = ($urandom_range(0, 15) == 0) ? 3'($urandom_range(2, 4)) : 3'd1;
      W_stat  = ($urandom_range(0, 60) == 0) ? 3'($urandom_range(2, 4)) : 3'd1;
      start   = ($urandom_range(0, 7) == 0);
      tick();
    end
    start = 1'b0;
    tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
